// File: rtl/dff_pipe_en_rst_if.sv
// Handshake/data bundle for the dff_pipe_en_rst staging pipe.
// master drives control and input beats; slave is the pipe itself.
interface dff_pipe_en_rst_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic             set;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output en, flush, set, in_valid, in_data,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  en, flush, set, in_valid, in_data,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/dff_pipe_en_rst.sv
// WIDTH-bit, DEPTH-stage stallable pipe with per-stage valid, flush, preset and async reset.
// Define DFF_PIPE_BUBBLE_COLLAPSE_EN to let beats slide into empty stages while stalled.
module dff_pipe_en_rst #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input logic              clk,
    input logic              rst_n,
    dff_pipe_en_rst_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_d;
    logic [CNT_W-1:0]            cnt;

`ifdef DFF_PIPE_BUBBLE_COLLAPSE_EN
    // A stage may load when the output is consumed or any stage at/after it is empty.
    always_comb begin : adv_collapse
        logic room;
        room = bus.en;
        adv  = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            room   = room | ~v_q[i];
            adv[i] = room;
        end
    end
`else
    assign adv = {DEPTH{bus.en}};
`endif

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (bus.flush) begin
            v_d = '0;
        end else if (bus.set) begin
            v_d = '1;
            d_d = {DEPTH{SET_VAL}};
        end else begin
            if (adv[0]) begin
                v_d[0] = bus.in_valid;
                if (bus.in_valid) begin
                    d_d[0] = bus.in_data;
                end
            end
            // Bubbles move forward as invalid, leaving stale data in place.
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            d_q <= {DEPTH{RST_VAL}};
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt = cnt + CNT_W'(v_q[i]);
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = d_q[DEPTH-1];
    assign bus.count     = cnt;
endmodule

// File: tb/tb_dff_pipe_en_rst.sv
// Bench for dff_pipe_en_rst: directed vector table, corner sequences and random traffic
// checked against a stage-list reference model.
module tb_dff_pipe_en_rst;
    localparam int unsigned W    = 8;
    localparam int unsigned D    = 3;
    localparam logic [7:0]  RSTV = 8'h00;
    localparam logic [7:0]  SETV = 8'hFF;
`ifdef DFF_PIPE_BUBBLE_COLLAPSE_EN
    localparam bit COLLAPSE = 1'b1;
`else
    localparam bit COLLAPSE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dff_pipe_en_rst_if #(.WIDTH(W), .DEPTH(D)) bus ();

    dff_pipe_en_rst #(
        .WIDTH  (W),
        .DEPTH  (D),
        .RST_VAL(RSTV),
        .SET_VAL(SETV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: list of stages, index 0 at the input.
    bit         mv[D];
    logic [7:0] md[D];

    typedef struct {
        logic       e, f, s, iv;
        logic [7:0] id;
        logic       ov;
        logic [7:0] od;
        logic [1:0] cnt;
        logic       rdy;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(int e, int f, int s, int iv, int id,
                                int ov, int od, int c, int rdy);
        vec_t v;
        v.e = (e != 0);  v.f = (f != 0);  v.s = (s != 0);  v.iv = (iv != 0);
        v.id = 8'(id);   v.ov = (ov != 0); v.od = 8'(od);  v.cnt = 2'(c);
        v.rdy = (rdy != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stage i can load if the pipe is advancing, or (collapse mode) a hole exists at/after i.
    function automatic bit m_adv(int i);
        if (bus.en) return 1'b1;
        if (!COLLAPSE) return 1'b0;
        for (int j = i; j < int'(D); j++) if (!mv[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < int'(D); i++) n += int'(mv[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(D); i++) begin
            mv[i] = 1'b0;
            md[i] = RSTV;
        end
    endtask

    task automatic m_edge();
        bit         nv[D];
        logic [7:0] nd[D];
        bit         a[D];
        for (int i = 0; i < int'(D); i++) a[i] = m_adv(i);
        nv = mv;
        nd = md;
        if (bus.flush) begin
            for (int i = 0; i < int'(D); i++) nv[i] = 1'b0;
        end else if (bus.set) begin
            for (int i = 0; i < int'(D); i++) begin
                nv[i] = 1'b1;
                nd[i] = SETV;
            end
        end else begin
            if (a[0]) begin
                nv[0] = bus.in_valid;
                if (bus.in_valid) nd[0] = bus.in_data;
            end
            for (int i = 1; i < int'(D); i++) begin
                if (a[i]) begin
                    nv[i] = mv[i-1];
                    if (mv[i-1]) nd[i] = md[i-1];
                end
            end
        end
        mv = nv;
        md = nd;
    endtask

    task automatic drive(input int e, input int f, input int s, input int iv, input int id);
        bus.en       = (e != 0);
        bus.flush    = (f != 0);
        bus.set      = (s != 0);
        bus.in_valid = (iv != 0);
        bus.in_data  = 8'(id);
    endtask

    task automatic clock();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(m_adv(0)));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mv[D-1]));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(md[D-1]));
        chk({tag, ".count"},     32'(bus.count),     m_cnt());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset.out_valid", 32'(bus.out_valid), 0);
        chk("reset.out_data",  32'(bus.out_data),  32'(RSTV));
        chk("reset.count",     32'(bus.count),     0);
        chk("reset.in_ready",  32'(bus.in_ready),  0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef DFF_PIPE_BUBBLE_COLLAPSE_EN
        // e f s iv id | ov od cnt rdy (outputs seen before the row's edge)
        tbl[0]  = mk(1, 0, 0, 1, 'h11, 0, 'h00, 0, 1);
        tbl[1]  = mk(1, 0, 0, 1, 'h22, 0, 'h00, 1, 1);
        tbl[2]  = mk(1, 0, 0, 1, 'h33, 0, 'h00, 2, 1);
        tbl[3]  = mk(1, 0, 0, 0, 'h00, 1, 'h11, 3, 1);
        tbl[4]  = mk(1, 0, 0, 0, 'h00, 1, 'h22, 2, 1);
        tbl[5]  = mk(1, 0, 0, 0, 'h00, 1, 'h33, 1, 1);
        tbl[6]  = mk(1, 0, 0, 1, 'hA0, 0, 'h33, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 'h5A, 0, 'h33, 1, 1);
        tbl[8]  = mk(1, 0, 0, 1, 'hA2, 0, 'h33, 1, 1);
        tbl[9]  = mk(1, 0, 0, 0, 'h00, 1, 'hA0, 2, 1);
        tbl[10] = mk(1, 0, 0, 0, 'h00, 0, 'hA0, 1, 1);
        tbl[11] = mk(1, 0, 0, 0, 'h00, 1, 'hA2, 1, 1);
        tbl[12] = mk(1, 0, 0, 1, 'h11, 0, 'hA2, 0, 1);
        tbl[13] = mk(1, 0, 0, 1, 'h22, 0, 'hA2, 1, 1);
        tbl[14] = mk(1, 0, 0, 0, 'h00, 0, 'hA2, 2, 1);
        tbl[15] = mk(0, 0, 0, 1, 'h44, 1, 'h11, 2, 0);
        tbl[16] = mk(0, 0, 0, 1, 'h44, 1, 'h11, 2, 0);
        tbl[17] = mk(0, 0, 0, 1, 'h44, 1, 'h11, 2, 0);
        tbl[18] = mk(0, 0, 0, 1, 'h44, 1, 'h11, 2, 0);
        tbl[19] = mk(1, 0, 0, 1, 'h44, 1, 'h11, 2, 1);
        tbl[20] = mk(1, 0, 0, 0, 'h00, 1, 'h22, 2, 1);
        tbl[21] = mk(1, 0, 0, 0, 'h00, 0, 'h22, 1, 1);
        tbl[22] = mk(1, 0, 0, 0, 'h00, 1, 'h44, 1, 1);
        tbl[23] = mk(0, 0, 1, 1, 'h77, 0, 'h44, 0, 0);
        tbl[24] = mk(0, 0, 0, 0, 'h00, 1, 'hFF, 3, 0);
        tbl[25] = mk(1, 1, 1, 1, 'h12, 1, 'hFF, 3, 1);
        tbl[26] = mk(0, 0, 0, 0, 'h00, 0, 'hFF, 0, 0);
        for (int k = 0; k < 27; k++) begin
            drive(int'(tbl[k].e), int'(tbl[k].f), int'(tbl[k].s), int'(tbl[k].iv),
                  int'(tbl[k].id));
            #1;
            chk($sformatf("vec%0d.out_valid", k), 32'(bus.out_valid), 32'(tbl[k].ov));
            chk($sformatf("vec%0d.out_data", k),  32'(bus.out_data),  32'(tbl[k].od));
            chk($sformatf("vec%0d.count", k),     32'(bus.count),     32'(tbl[k].cnt));
            chk($sformatf("vec%0d.in_ready", k),  32'(bus.in_ready),  32'(tbl[k].rdy));
            clock();
        end
`else
        // Stalled pipe with one beat in stage 0 fills up from the input side.
        drive(1, 0, 0, 1, 'h50);
        clock();
        drive(0, 0, 0, 1, 'h55);
        #1;
        chk("collapse.rdy1", 32'(bus.in_ready), 1);
        chk("collapse.cnt1", 32'(bus.count), 1);
        clock();
        drive(0, 0, 0, 1, 'h56);
        #1;
        chk("collapse.rdy2", 32'(bus.in_ready), 1);
        chk("collapse.cnt2", 32'(bus.count), 2);
        chk("collapse.ov2",  32'(bus.out_valid), 0);
        clock();
        drive(0, 0, 0, 1, 'h57);
        #1;
        chk("collapse.rdy3", 32'(bus.in_ready), 0);
        chk("collapse.cnt3", 32'(bus.count), 3);
        chk("collapse.ov3",  32'(bus.out_valid), 1);
        chk("collapse.od3",  32'(bus.out_data), 'h50);
        clock();
        #1;
        chk("collapse.hold_rdy", 32'(bus.in_ready), 0);
        chk("collapse.hold_cnt", 32'(bus.count), 3);
        drive(1, 0, 0, 0, 0);
        #1;
        check_model("collapse.drain");
        clock();
        check_model("collapse.drain2");
`endif

        // Asynchronous reset between edges while two beats are in flight.
        do_reset();
        drive(1, 0, 0, 1, 'h61);
        clock();
        drive(1, 0, 0, 1, 'h62);
        clock();
        #1;
        chk("arst.pre_count", 32'(bus.count), 2);
        drive(1, 0, 0, 1, 'h63);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst.out_valid", 32'(bus.out_valid), 0);
        chk("arst.out_data",  32'(bus.out_data),  32'(RSTV));
        chk("arst.count",     32'(bus.count),     0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst.held_count", 32'(bus.count), 0);
        chk("arst.held_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 29) == 0), int'($urandom_range(0, 9) < 6),
                  int'($urandom_range(0, 255)));
            #1;
            check_model($sformatf("rnd%0d", k));
            clock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
